// File: rtl/issue_queue_mp.sv
// Parametrised multi-port circular issue queue: up to PUSH_W in-order pushes and POP_W peeked pops per cycle.
// Optional macro IQ_HWM_EN enables the high-water-mark register on o_hwm (tied to 0 otherwise).
module issue_queue_mp #(
    parameter int DEPTH  = 16,
    parameter int PUSH_W = 4,
    parameter int POP_W  = 2,
    parameter int DATA_W = 64
) (
    input  logic                         i_clk,
    input  logic                         i_rst,
    input  logic                         i_flush,
    input  logic [$clog2(PUSH_W+1)-1:0]  i_push_num,
    input  logic [PUSH_W*DATA_W-1:0]     i_push_data,
    output logic [$clog2(DEPTH+1)-1:0]   o_size_left,
    output logic [$clog2(DEPTH+1)-1:0]   o_size,
    input  logic [$clog2(POP_W+1)-1:0]   i_pop_num,
    output logic [POP_W*DATA_W-1:0]      o_pop_data,
    output logic [POP_W-1:0]             o_pop_valid,
    output logic                         o_push_ovf,
    output logic                         o_pop_unf,
    output logic [$clog2(DEPTH+1)-1:0]   o_hwm
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH+1);

    logic [PTR_W-1:0]  r_head;
    logic [PTR_W-1:0]  r_tail;
    logic [CNT_W-1:0]  r_count;
    logic [DATA_W-1:0] r_mem [DEPTH];
    logic              r_push_ovf;
    logic              r_pop_unf;

    logic [CNT_W-1:0]  w_size_left;
    logic [CNT_W-1:0]  w_push_ext;
    logic [CNT_W-1:0]  w_pop_ext;
    logic [CNT_W-1:0]  w_pushed;
    logic [CNT_W-1:0]  w_popped;
    logic [CNT_W-1:0]  w_count_next;
    logic              w_push_ok;
    logic              w_pop_unf;

    // Push capacity uses the registered free space only; this cycle's pop frees nothing until next cycle.
    always_comb begin
        w_size_left  = CNT_W'(DEPTH) - r_count;
        w_push_ext   = CNT_W'(i_push_num);
        w_pop_ext    = CNT_W'(i_pop_num);
        w_push_ok    = (w_push_ext <= w_size_left);
        w_pushed     = w_push_ok ? w_push_ext : '0;
        w_pop_unf    = (w_pop_ext > r_count);
        w_popped     = w_pop_unf ? r_count : w_pop_ext;
        w_count_next = i_flush ? '0 : (r_count + w_pushed - w_popped);
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_head     <= '0;
            r_tail     <= '0;
            r_count    <= '0;
            r_push_ovf <= 1'b0;
            r_pop_unf  <= 1'b0;
        end else if (i_flush) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            r_tail  <= r_tail + PTR_W'(w_pushed);
            r_head  <= r_head + PTR_W'(w_popped);
            r_count <= w_count_next;
            if (!w_push_ok) begin
                r_push_ovf <= 1'b1;
            end
            if (w_pop_unf) begin
                r_pop_unf <= 1'b1;
            end
        end
    end

    // Storage is deliberately not reset; pointer arithmetic wraps naturally since DEPTH is a power of two.
    always_ff @(posedge i_clk) begin
        if (!i_rst && !i_flush && w_push_ok) begin
            for (int i = 0; i < PUSH_W; i++) begin
                if (CNT_W'(i) < w_push_ext) begin
                    r_mem[r_tail + PTR_W'(i)] <= i_push_data[i*DATA_W +: DATA_W];
                end
            end
        end
    end

    always_comb begin
        o_pop_data  = '0;
        o_pop_valid = '0;
        for (int j = 0; j < POP_W; j++) begin
            o_pop_data[j*DATA_W +: DATA_W] = r_mem[r_head + PTR_W'(j)];
            o_pop_valid[j]                 = (CNT_W'(j) < r_count);
        end
    end

    assign o_size      = r_count;
    assign o_size_left = w_size_left;
    assign o_push_ovf  = r_push_ovf;
    assign o_pop_unf   = r_pop_unf;

`ifdef IQ_HWM_EN
    logic [CNT_W-1:0] r_hwm;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_hwm <= '0;
        end else if (w_count_next > r_hwm) begin
            r_hwm <= w_count_next;
        end
    end

    assign o_hwm = r_hwm;
`else
    assign o_hwm = '0;
`endif

endmodule

// File: tb/tb_issue_queue_mp.sv
// Directed self-checking bench for issue_queue_mp with hand-computed expectations.
// Checks hwm against 16 when IQ_HWM_EN is defined, against 0 otherwise.
module tb_issue_queue_mp;

    localparam int DEPTH  = 16;
    localparam int PUSH_W = 4;
    localparam int POP_W  = 2;
    localparam int DATA_W = 64;

    logic                        clk;
    logic                        rst;
    logic                        flush;
    logic [2:0]                  pushNum;
    logic [PUSH_W*DATA_W-1:0]    pushData;
    logic [4:0]                  sizeLeft;
    logic [4:0]                  size;
    logic [1:0]                  popNum;
    logic [POP_W*DATA_W-1:0]     popData;
    logic [POP_W-1:0]            popValid;
    logic                        pushOvf;
    logic                        popUnf;
    logic [4:0]                  hwm;

    int vectors;
    int miscompares;

    issue_queue_mp #(
        .DEPTH (DEPTH),
        .PUSH_W(PUSH_W),
        .POP_W (POP_W),
        .DATA_W(DATA_W)
    ) dut (
        .i_clk      (clk),
        .i_rst      (rst),
        .i_flush    (flush),
        .i_push_num (pushNum),
        .i_push_data(pushData),
        .o_size_left(sizeLeft),
        .o_size     (size),
        .i_pop_num  (popNum),
        .o_pop_data (popData),
        .o_pop_valid(popValid),
        .o_push_ovf (pushOvf),
        .o_pop_unf  (popUnf),
        .o_hwm      (hwm)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [63:0] dat(input int k);
        return 64'hD000_0000_0000_0000 | 64'(k);
    endfunction

    function automatic logic [PUSH_W*DATA_W-1:0] grp(input int k);
        return {dat(k+3), dat(k+2), dat(k+1), dat(k)};
    endfunction

    // One clock of stimulus; returns #1 after the edge with inputs idle again.
    task automatic applyStimulus(input int pn, input logic [PUSH_W*DATA_W-1:0] pd,
                                 input int pp, input logic fl);
        pushNum  = 3'(pn);
        pushData = pd;
        popNum   = 2'(pp);
        flush    = fl;
        @(posedge clk);
        #1;
        pushNum  = '0;
        popNum   = '0;
        flush    = 1'b0;
    endtask

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic checkHwm(input string tag, input int expEnabled);
`ifdef IQ_HWM_EN
        checkOutput(tag, 64'(hwm), 64'(expEnabled));
`else
        checkOutput(tag, 64'(hwm), 64'(0) & 64'(expEnabled));
`endif
    endtask

    task automatic doReset();
        #2;
        rst = 1'b1;
        #3;
        rst = 1'b0;
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst      = 1'b1;
        flush    = 1'b0;
        pushNum  = '0;
        pushData = '0;
        popNum   = '0;

        #12;
        checkOutput("rst_size",      64'(size),     64'd0);
        checkOutput("rst_size_left", 64'(sizeLeft), 64'd16);
        checkOutput("rst_valid",     64'(popValid), 64'd0);
        checkOutput("rst_ovf",       64'(pushOvf),  64'd0);
        checkOutput("rst_unf",       64'(popUnf),   64'd0);
        checkOutput("rst_hwm",       64'(hwm),      64'd0);
        rst = 1'b0;

        // Fill to full, then an overflowing push of one.
        applyStimulus(4, grp(0), 0, 1'b0);
        checkOutput("t1_size4",   64'(size),     64'd4);
        checkOutput("t1_slot0",   popData[63:0], dat(0));
        applyStimulus(4, grp(4), 0, 1'b0);
        applyStimulus(4, grp(8), 0, 1'b0);
        applyStimulus(4, grp(12), 0, 1'b0);
        checkOutput("t1_full_size", 64'(size),     64'd16);
        checkOutput("t1_full_left", 64'(sizeLeft), 64'd0);
        checkOutput("t1_full_ovf0", 64'(pushOvf),  64'd0);
        applyStimulus(1, grp(99), 0, 1'b0);
        checkOutput("t1_ovf",       64'(pushOvf),  64'd1);
        checkOutput("t1_ovf_size",  64'(size),     64'd16);
        checkOutput("t1_slot1",     popData[127:64], dat(1));
        checkHwm("t1_hwm", 16);
        applyStimulus(0, '0, 0, 1'b1);
        checkOutput("t1_flush_size", 64'(size),   64'd0);
        checkOutput("t1_flush_ovf",  64'(pushOvf), 64'd1);
        checkHwm("t1_flush_hwm", 16);
        doReset();
        checkOutput("t1_rst_ovf", 64'(pushOvf), 64'd0);
        checkOutput("t1_rst_hwm", 64'(hwm),     64'd0);

        // Push A,B,C then pop two; then underflow pop on a single entry.
        applyStimulus(3, {64'hFFFF, 64'hCCCC, 64'hBBBB, 64'hAAAA}, 0, 1'b0);
        checkOutput("t2_valid", 64'(popValid),     64'd3);
        checkOutput("t2_slot0", popData[63:0],     64'hAAAA);
        checkOutput("t2_slot1", popData[127:64],   64'hBBBB);
        applyStimulus(0, '0, 2, 1'b0);
        checkOutput("t2_pop_slot0", popData[63:0], 64'hCCCC);
        checkOutput("t2_pop_valid", 64'(popValid), 64'd1);
        checkOutput("t2_pop_size",  64'(size),     64'd1);
        applyStimulus(0, '0, 2, 1'b0);
        checkOutput("t6_size", 64'(size),   64'd0);
        checkOutput("t6_unf",  64'(popUnf), 64'd1);
        checkOutput("t6_valid", 64'(popValid), 64'd0);
        doReset();

        // Wrap-around: fill 14, pop 14, then push four across index 15 -> 0.
        applyStimulus(4, grp(100), 0, 1'b0);
        applyStimulus(4, grp(104), 0, 1'b0);
        applyStimulus(4, grp(108), 0, 1'b0);
        applyStimulus(2, grp(112), 0, 1'b0);
        checkOutput("t3_size14", 64'(size), 64'd14);
        for (int k = 0; k < 7; k++) applyStimulus(0, '0, 2, 1'b0);
        checkOutput("t3_empty", 64'(size), 64'd0);
        applyStimulus(4, grp(200), 0, 1'b0);
        checkOutput("t3_w_slot0", popData[63:0],   dat(200));
        checkOutput("t3_w_slot1", popData[127:64], dat(201));
        applyStimulus(0, '0, 2, 1'b0);
        checkOutput("t3_w_slot2", popData[63:0],   dat(202));
        checkOutput("t3_w_slot3", popData[127:64], dat(203));
        checkOutput("t3_unf_kept", 64'(popUnf), 64'd0);
        doReset();

        // Simultaneous push/pop when full and when partly full.
        applyStimulus(4, grp(0), 0, 1'b0);
        applyStimulus(4, grp(4), 0, 1'b0);
        applyStimulus(4, grp(8), 0, 1'b0);
        applyStimulus(4, grp(12), 0, 1'b0);
        applyStimulus(2, grp(50), 2, 1'b0);
        checkOutput("t4_full_size", 64'(size),    64'd14);
        checkOutput("t4_full_ovf",  64'(pushOvf), 64'd1);
        checkOutput("t4_full_slot0", popData[63:0], dat(2));
        applyStimulus(0, '0, 2, 1'b0);
        applyStimulus(0, '0, 2, 1'b0);
        checkOutput("t4_size10", 64'(size), 64'd10);
        applyStimulus(3, grp(60), 2, 1'b0);
        checkOutput("t4_size11",  64'(size),       64'd11);
        checkOutput("t4_left5",   64'(sizeLeft),   64'd5);
        checkOutput("t4_slot0",   popData[63:0],   dat(8));
        checkOutput("t4_slot1",   popData[127:64], dat(9));
        checkHwm("t4_hwm", 16);

        // Flush with concurrent push/pop, then async reset mid-cycle.
        applyStimulus(0, '0, 2, 1'b0);
        applyStimulus(0, '0, 2, 1'b0);
        applyStimulus(0, '0, 2, 1'b0);
        checkOutput("t5_size5", 64'(size), 64'd5);
        applyStimulus(4, grp(70), 2, 1'b1);
        checkOutput("t5_fl_size",  64'(size),     64'd0);
        checkOutput("t5_fl_valid", 64'(popValid), 64'd0);
        checkOutput("t5_fl_left",  64'(sizeLeft), 64'd16);
        checkOutput("t5_fl_ovf",   64'(pushOvf),  64'd1);
        applyStimulus(2, grp(80), 0, 1'b0);
        checkOutput("t5_post_slot0", popData[63:0], dat(80));
        #2;
        rst = 1'b1;
        #1;
        checkOutput("t5_arst_size",  64'(size),     64'd0);
        checkOutput("t5_arst_valid", 64'(popValid), 64'd0);
        checkOutput("t5_arst_ovf",   64'(pushOvf),  64'd0);
        checkOutput("t5_arst_left",  64'(sizeLeft), 64'd16);
        #2;
        rst = 1'b0;
        applyStimulus(0, '0, 0, 1'b0);
        checkOutput("t5_idle_size", 64'(size), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
